// File: rtl/tb_data_demux.sv
// Core data-port router for the HWPE bench: steers LSU requests to periph/stack/TCDM and absorbs mailbox writes.
// Optional macro TB_DEMUX_PROTOCOL_CHECK_EN adds a sticky protocol-error flag (stray responses, unstable requests).
module tb_data_demux #(
  parameter int unsigned HWPE_ADDR_BASE_BIT = 20,
  parameter int unsigned MAX_OUTSTANDING    = 2,
  parameter logic [31:0] MAILBOX_ADDR       = 32'h8000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic [2:0]       tgt_req_o,
  input  logic [2:0]       tgt_gnt_i,
  output logic [2:0][31:0] tgt_add_o,
  output logic [2:0]       tgt_wen_o,
  output logic [2:0][3:0]  tgt_be_o,
  output logic [2:0][31:0] tgt_data_o,
  input  logic [2:0]       tgt_r_valid_i,
  input  logic [2:0][31:0] tgt_r_data_i,
  output logic             mbox_valid_o,
  output logic [31:0]      mbox_data_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {
    TGT_PERIPH = 2'd0,
    TGT_STACK  = 2'd1,
    TGT_TCDM   = 2'd2,
    TGT_MBOX   = 2'd3
  } target_e;

  target_e          sel;
  logic [1:0]       head;
  logic [1:0]       id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] occ, mbox_pend;
  logic             fifo_full, fifo_empty;
  logic             push, pop, mb_push, mb_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A mailbox match needs a write; a mailbox-address read falls through to normal decode.
  always_comb begin
    if (data_we_i && (data_addr_i == MAILBOX_ADDR)) sel = TGT_MBOX;
    else if (data_addr_i[HWPE_ADDR_BASE_BIT])       sel = TGT_PERIPH;
    else if (data_addr_i[31:24] == 8'h00)           sel = TGT_STACK;
    else                                            sel = TGT_TCDM;
  end

  assign fifo_full  = (occ == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (occ == '0);
  assign head       = id_mem[rd_ptr];

  always_comb begin
    tgt_req_o  = '0;
    data_gnt_o = 1'b0;
    if (!rst_i && data_req_i && !fifo_full) begin
      if (sel == TGT_MBOX) begin
        data_gnt_o = 1'b1;
      end else begin
        tgt_req_o[sel] = 1'b1;
        data_gnt_o     = tgt_gnt_i[sel];
      end
    end
  end

  always_comb begin
    tgt_add_o[0] = data_addr_i;
    tgt_add_o[1] = data_addr_i;
    tgt_add_o[2] = {8'h00, data_addr_i[23:0]};
  end

  assign tgt_wen_o  = {3{~data_we_i}};
  assign tgt_be_o   = {3{data_be_i}};
  assign tgt_data_o = {3{data_wdata_i}};

  // Responses come back strictly in issue order, so only the head source is listened to.
  always_comb begin
    data_rvalid_o = 1'b0;
    data_rdata_o  = '0;
    if (!rst_i && !fifo_empty) begin
      case (head)
        2'd0: begin data_rvalid_o = tgt_r_valid_i[0]; data_rdata_o = tgt_r_valid_i[0] ? tgt_r_data_i[0] : '0; end
        2'd1: begin data_rvalid_o = tgt_r_valid_i[1]; data_rdata_o = tgt_r_valid_i[1] ? tgt_r_data_i[1] : '0; end
        2'd2: begin data_rvalid_o = tgt_r_valid_i[2]; data_rdata_o = tgt_r_valid_i[2] ? tgt_r_data_i[2] : '0; end
        default: data_rvalid_o = (mbox_pend != '0);
      endcase
    end
  end

  assign push    = data_gnt_o;
  assign pop     = data_rvalid_o;
  assign mb_push = push && (sel == TGT_MBOX);
  assign mb_pop  = pop && (head == TGT_MBOX);

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= sel;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Mailbox responses are counted so one still waits if an earlier transaction holds the head.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mbox_pend    <= '0;
      mbox_valid_o <= 1'b0;
      mbox_data_o  <= '0;
    end else begin
      case ({mb_push, mb_pop})
        2'b10:   mbox_pend <= mbox_pend + 1'b1;
        2'b01:   mbox_pend <= mbox_pend - 1'b1;
        default: mbox_pend <= mbox_pend;
      endcase
      if (mb_push) begin
        mbox_valid_o <= 1'b1;
        mbox_data_o  <= data_wdata_i;
      end
    end
  end

`ifdef TB_DEMUX_PROTOCOL_CHECK_EN
  logic        stray, drop, req_wait_q, err_q;
  logic [1:0]  stray_tgt;
  logic [31:0] addr_q, cycle_q;

  always_comb begin
    stray     = 1'b0;
    stray_tgt = '0;
    for (int t = 0; t < 3; t++) begin
      if (tgt_r_valid_i[t] && (fifo_empty || head != 2'(t))) begin
        stray     = 1'b1;
        stray_tgt = 2'(t);
      end
    end
  end

  assign drop = req_wait_q && (!data_req_i || (data_addr_i != addr_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_wait_q <= 1'b0;
      addr_q     <= '0;
      cycle_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      cycle_q    <= cycle_q + 1'b1;
      req_wait_q <= data_req_i && !data_gnt_o;
      addr_q     <= data_addr_i;
      if (stray || drop) begin
        err_q <= 1'b1;
        if (!err_q) $error("tb_data_demux protocol error at cycle %0d target %0d", cycle_q, stray_tgt);
      end
    end
  end

  assign data_err_o = err_q;
`else
  assign data_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tb_data_demux.sv
// Directed self-checking bench for tb_data_demux: decode, ordering, back-pressure, mailbox, stray responses, reset.
module tb_tb_data_demux;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             data_req_i, data_we_i;
  logic [3:0]       data_be_i;
  logic [31:0]      data_addr_i, data_wdata_i;
  logic             data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]      data_rdata_o;
  logic [2:0]       tgt_req_o, tgt_gnt_i, tgt_wen_o, tgt_r_valid_i;
  logic [2:0][31:0] tgt_add_o, tgt_data_o, tgt_r_data_i;
  logic [2:0][3:0]  tgt_be_o;
  logic             mbox_valid_o;
  logic [31:0]      mbox_data_o;

  int checks = 0;
  int errors = 0;

`ifdef TB_DEMUX_PROTOCOL_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  tb_data_demux dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .tgt_req_o(tgt_req_o), .tgt_gnt_i(tgt_gnt_i), .tgt_add_o(tgt_add_o),
    .tgt_wen_o(tgt_wen_o), .tgt_be_o(tgt_be_o), .tgt_data_o(tgt_data_o),
    .tgt_r_valid_i(tgt_r_valid_i), .tgt_r_data_i(tgt_r_data_i),
    .mbox_valid_o(mbox_valid_o), .mbox_data_o(mbox_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] gnt, input logic [2:0] rvalid);
    data_req_i    = req;
    data_we_i     = we;
    data_be_i     = 4'hF;
    data_addr_i   = addr;
    data_wdata_i  = wdata;
    tgt_gnt_i     = gnt;
    tgt_r_valid_i = rvalid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; checks sample 1 time unit later, well clear of the rising edge.
  initial begin
    rst_i        = 1'b1;
    tgt_r_data_i = '0;
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 3'b000);
    #7;
    checkOutput("rst_tgt_req", 32'(tgt_req_o), 32'h0);
    checkOutput("rst_gnt", 32'(data_gnt_o), 32'h0);
    checkOutput("rst_rvalid", 32'(data_rvalid_o), 32'h0);
    checkOutput("rst_err", 32'(data_err_o), 32'h0);
    checkOutput("rst_mbox_valid", 32'(mbox_valid_o), 32'h0);
    checkOutput("rst_mbox_data", mbox_data_o, 32'h0);

    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    rst_i = 1'b0;

    // Stack read, granted at once, answered the following cycle.
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 3'b000);
    #1;
    checkOutput("rd_stack_req", 32'(tgt_req_o), 32'h2);
    checkOutput("rd_stack_gnt", 32'(data_gnt_o), 32'h1);
    checkOutput("rd_stack_add", tgt_add_o[1], 32'h0000_0100);
    checkOutput("rd_stack_wen", 32'(tgt_wen_o[1]), 32'h1);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b010);
    tgt_r_data_i[1] = 32'hDEAD_BEEF;
    #1;
    checkOutput("rd_stack_rvalid", 32'(data_rvalid_o), 32'h1);
    checkOutput("rd_stack_rdata", data_rdata_o, 32'hDEAD_BEEF);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    #1;
    checkOutput("rd_stack_idle_rvalid", 32'(data_rvalid_o), 32'h0);
    checkOutput("rd_stack_idle_rdata", data_rdata_o, 32'h0);

    // TCDM write: upper address byte stripped, active-low write enable.
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b1, 32'h0100_0040, 32'h1234_5678, 3'b100, 3'b000);
    #1;
    checkOutput("wr_tcdm_req", 32'(tgt_req_o), 32'h4);
    checkOutput("wr_tcdm_add", tgt_add_o[2], 32'h0000_0040);
    checkOutput("wr_tcdm_wen", 32'(tgt_wen_o[2]), 32'h0);
    checkOutput("wr_tcdm_data", tgt_data_o[2], 32'h1234_5678);
    checkOutput("wr_tcdm_gnt", 32'(data_gnt_o), 32'h1);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b100);
    tgt_r_data_i[2] = 32'h0;
    #1;
    checkOutput("wr_tcdm_rvalid", 32'(data_rvalid_o), 32'h1);

    // Address bit 20 selects the peripheral.
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b1, 32'h0010_0000, 32'h0000_00AA, 3'b001, 3'b000);
    #1;
    checkOutput("wr_periph_req", 32'(tgt_req_o), 32'h1);
    checkOutput("wr_periph_add", tgt_add_o[0], 32'h0010_0000);
    checkOutput("wr_periph_gnt", 32'(data_gnt_o), 32'h1);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b001);
    tgt_r_data_i[0] = 32'hA5A5_A5A5;
    #1;
    checkOutput("wr_periph_rdata", data_rdata_o, 32'hA5A5_A5A5);

    // Two outstanding (TCDM then stack), third request held until the slow TCDM answer pops.
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0200_0010, 32'h0, 3'b100, 3'b000);
    #1;
    checkOutput("full_a_gnt", 32'(data_gnt_o), 32'h1);
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b010, 3'b000);
    #1;
    checkOutput("full_b_gnt", 32'(data_gnt_o), 32'h1);
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'b010, 3'b000);
    #1;
    checkOutput("full_c_req", 32'(tgt_req_o), 32'h0);
    checkOutput("full_c_gnt", 32'(data_gnt_o), 32'h0);
    checkOutput("full_c_rvalid", 32'(data_rvalid_o), 32'h0);
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'b010, 3'b100);
    tgt_r_data_i[2] = 32'h1111_1111;
    #1;
    checkOutput("full_a_rvalid", 32'(data_rvalid_o), 32'h1);
    checkOutput("full_a_rdata", data_rdata_o, 32'h1111_1111);
    checkOutput("full_c_gnt_still", 32'(data_gnt_o), 32'h0);
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'b010, 3'b000);
    #1;
    checkOutput("full_c_req_late", 32'(tgt_req_o), 32'h2);
    checkOutput("full_c_gnt_late", 32'(data_gnt_o), 32'h1);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b010);
    tgt_r_data_i[1] = 32'h2222_2222;
    #1;
    checkOutput("full_b_rdata", data_rdata_o, 32'h2222_2222);
    @(negedge clk_i);
    tgt_r_data_i[1] = 32'h3333_3333;
    #1;
    checkOutput("full_c_rdata", data_rdata_o, 32'h3333_3333);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    #1;
    checkOutput("full_drain_rvalid", 32'(data_rvalid_o), 32'h0);

    // Mailbox write is absorbed locally and answered one cycle later with zero.
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0005, 3'b000, 3'b000);
    #1;
    checkOutput("mbox_tgt_req", 32'(tgt_req_o), 32'h0);
    checkOutput("mbox_gnt", 32'(data_gnt_o), 32'h1);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    #1;
    checkOutput("mbox_valid", 32'(mbox_valid_o), 32'h1);
    checkOutput("mbox_data", mbox_data_o, 32'h0000_0005);
    checkOutput("mbox_rvalid", 32'(data_rvalid_o), 32'h1);
    checkOutput("mbox_rdata", data_rdata_o, 32'h0);
    @(negedge clk_i);
    #1;
    checkOutput("mbox_rvalid_once", 32'(data_rvalid_o), 32'h0);

    // A read of the mailbox address is not a mailbox access; it decodes to TCDM.
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h0, 3'b100, 3'b000);
    #1;
    checkOutput("mbox_rd_req", 32'(tgt_req_o), 32'h4);
    checkOutput("mbox_rd_add", tgt_add_o[2], 32'h0);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b100);
    tgt_r_data_i[2] = 32'h0000_0055;
    #1;
    checkOutput("mbox_rd_rdata", data_rdata_o, 32'h0000_0055);

    // Stray peripheral response with nothing outstanding.
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b001);
    tgt_r_data_i[0] = 32'h0000_0BAD;
    #1;
    checkOutput("stray_rvalid", 32'(data_rvalid_o), 32'h0);
    checkOutput("stray_rdata", data_rdata_o, 32'h0);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    #1;
    checkOutput("stray_err", 32'(data_err_o), EXP_ERR);
    @(negedge clk_i);
    #1;
    checkOutput("stray_err_sticky", 32'(data_err_o), EXP_ERR);

    // Reset with two transactions in flight.
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0200_0020, 32'h0, 3'b100, 3'b000);
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0000_0500, 32'h0, 3'b010, 3'b000);
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0000_0600, 32'h0, 3'b010, 3'b100);
    tgt_r_data_i[2] = 32'h4444_4444;
    rst_i = 1'b1;
    #1;
    checkOutput("arst_tgt_req", 32'(tgt_req_o), 32'h0);
    checkOutput("arst_gnt", 32'(data_gnt_o), 32'h0);
    checkOutput("arst_rvalid", 32'(data_rvalid_o), 32'h0);
    checkOutput("arst_mbox_valid", 32'(mbox_valid_o), 32'h0);
    checkOutput("arst_err", 32'(data_err_o), 32'h0);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    rst_i = 1'b0;
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b100);
    #1;
    checkOutput("post_rst_late_rvalid", 32'(data_rvalid_o), 32'h0);
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h0000_0700, 32'h0, 3'b010, 3'b000);
    #1;
    checkOutput("post_rst_req", 32'(tgt_req_o), 32'h2);
    checkOutput("post_rst_gnt", 32'(data_gnt_o), 32'h1);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b010);
    tgt_r_data_i[1] = 32'hCAFE_F00D;
    #1;
    checkOutput("post_rst_rvalid", 32'(data_rvalid_o), 32'h1);
    checkOutput("post_rst_rdata", data_rdata_o, 32'hCAFE_F00D);
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    #1;
    checkOutput("post_rst_idle", 32'(data_rvalid_o), 32'h0);
    checkOutput("post_rst_err", 32'(data_err_o), EXP_ERR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_data_demux.md
Name: tb_data_demux

Overview:
- Sequential router on the core data port of the HWPE testbench.
- Sits between the zeroriscy data LSU port and three memory-side slaves: HWPE peripheral, stack memory and shared TCDM memory.
- Decodes each granted request to a target and tracks outstanding transactions in an in-order ID FIFO, so every r_valid/r_data is steered back from the correct slave.
- Absorbs writes to the end-of-test mailbox locally and exposes the written value to the bench.

Parameters:
- HWPE_ADDR_BASE_BIT, 20: address bit that selects the peripheral target.
- MAX_OUTSTANDING, 2: depth of the outstanding-target FIFO (power of 2, at least 1).
- MAILBOX_ADDR, 32'h80000000: write-only mailbox address, handled locally.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- data_req_i  in  1  core request
- data_gnt_o  out  1  grant to core
- data_we_i  in  1  core write enable (1 = write)
- data_be_i  in  4  byte enables
- data_addr_i  in  32  address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid to core
- data_rdata_o  out  32  response data
- data_err_o  out  1  sticky protocol error
- tgt_req_o  out  3  request per target [0]=periph [1]=stack [2]=tcdm
- tgt_gnt_i  in  3  grant per target
- tgt_add_o  out  3x32  address per target
- tgt_wen_o  out  3  active-low write enable per target (1 = read)
- tgt_be_o  out  3x4  byte enables per target
- tgt_data_o  out  3x32  write data per target
- tgt_r_valid_i  in  3  response valid per target
- tgt_r_data_i  in  3x32  response data per target
- mbox_valid_o  out  1  mailbox has been written
- mbox_data_o  out  32  last mailbox value

Behaviour:
- Reset (rst_i high, asynchronous): FIFO empty; data_err_o=0; mbox_valid_o=0; mbox_data_o=0; internal mailbox response pending=0.
- Reset state forces all comb outputs low: tgt_req_o=0, data_gnt_o=0, data_rvalid_o=0.
- Reset mid-transaction drops all in-flight IDs; responses arriving later count as unexpected.
- Decode, with priority in this order:
  - MB: data_we_i & addr==MAILBOX_ADDR.
  - PERIPH: addr[HWPE_ADDR_BASE_BIT].
  - STACK: addr[31:24]==0.
  - TCDM: everything else.
- Target addresses:
  - tgt_add_o[2] = {8'b0, addr[23:0]}.
  - Periph and stack get the full address.
- Write-data fanout: wen=~data_we_i; be and data broadcast to all targets.
- Request path (combinational): tgt_req_o[t] = data_req_i & sel==t & ~fifo_full.
- Grant path: data_gnt_o = selected tgt_gnt_i & ~fifo_full.
  - MB is granted immediately if not full.
- Handshake: a grant pushes the target ID (0..3, 3=MB) into the FIFO on the same clock edge.
- Mailbox write:
  - mbox_data_o <= data_wdata_i and mbox_valid_o <= 1 on the grant edge.
  - Internal response asserted exactly 1 cycle later with rdata=0.
- Response path:
  - head = FIFO head ID.
  - data_rvalid_o = r_valid of head source; data_rdata_o = its r_data (0 when not valid).
  - Pop on data_rvalid_o.
- Simultaneous push and pop are allowed: occupancy is unchanged, pointers both advance.
- Full FIFO: requests held off (no tgt_req_o, no grant) until a pop.
- Empty FIFO: data_rvalid_o=0.
- Pointer wrap: modulo MAX_OUTSTANDING; occupancy counter has width clog2(MAX_OUTSTANDING)+1.

Optional Feature:
- Macro: TB_DEMUX_PROTOCOL_CHECK_EN.
- Defined:
  - data_err_o is set sticky when any tgt_r_valid_i is asserted for a non-head target or with an empty FIFO.
  - data_err_o is also set when the core drops data_req_i or changes the address while a request is ungranted.
  - On the first set, $error prints the cycle and target.
- Undefined: data_err_o tied 0; stray responses are ignored; no checking logic is synthesized.

Test Plan:
- Read addr 0x00000100, stack grants in the same cycle, r_valid next cycle with 0xDEADBEEF -> tgt_req_o=3'b010, data_gnt_o=1, data_rvalid_o=1 with rdata 0xDEADBEEF one cycle later, FIFO empty.
- Write 0x01000040 -> tgt_req_o[2]=1, tgt_add_o[2]=0x00000040, tgt_wen_o[2]=0; write 0x00100000 -> periph selected.
- MAX_OUTSTANDING=2, back-to-back reads to TCDM then stack with TCDM response delayed 3 cycles -> third request held with gnt=0; responses returned in issue order TCDM then stack.
- Write 0x00000005 to 0x80000000 -> no tgt_req_o; gnt same cycle; rvalid next cycle; mbox_valid_o=1, mbox_data_o=5.
- tgt_r_valid_i[0]=1 with empty FIFO, macro defined -> data_err_o=1 and stays 1; macro undefined -> data_err_o=0, data_rvalid_o=0.
- Assert rst_i with 2 outstanding -> outputs 0 asynchronously; after release, a new read completes normally.
